// File: rtl/cpu_pkg.sv
// Shared core package: register-file dump defaults and state encoding.
// Used by regfile_dump and its stream interface.
package cpu_pkg;

    localparam int DUMP_XLEN  = 32;
    localparam int DUMP_NREGS = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_CSUM,
        S_DONE
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// Output beat stream of the register-file dump (valid/ready).
// master = dump engine, slave = consumer.
interface regfile_dump_if
    import cpu_pkg::*;
#(
    parameter int XLEN  = DUMP_XLEN,
    parameter int NREGS = DUMP_NREGS
);
    localparam int IW = $clog2(NREGS);

    logic            out_valid;
    logic            out_ready;
    logic [IW-1:0]   out_idx;
    logic [XLEN-1:0] out_data;
    logic            out_last;

    modport master (
        output out_valid,
        output out_idx,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_data,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/regfile_dump.sv
// Walks the register file and streams every register out as one beat.
// Define DUMP_CHECKSUM_EN to append a trailing XOR-checksum beat.
module regfile_dump
    import cpu_pkg::*;
#(
    parameter int XLEN  = DUMP_XLEN,
    parameter int NREGS = DUMP_NREGS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(NREGS)-1:0] rf_raddr,
    input  logic [XLEN-1:0]          rf_rdata,
    regfile_dump_if.master           dump
);

    localparam int            IW       = $clog2(NREGS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREGS - 1);

    dump_state_t     state;
    logic [IW-1:0]   idx;
    logic [XLEN-1:0] data;
    logic            accept;

`ifdef DUMP_CHECKSUM_EN
    logic [XLEN-1:0] acc;
`endif

    assign accept        = dump.out_valid && dump.out_ready;
    assign rf_raddr      = idx;
    assign dump.out_data = data;

`ifdef DUMP_CHECKSUM_EN
    // The checksum beat always reports index 0.
    assign dump.out_idx = (state == S_CSUM) ? '0 : idx;
`else
    assign dump.out_idx = idx;
`endif

    // Dump sequencer with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            idx            <= '0;
            data           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            dump.out_valid <= 1'b0;
            dump.out_last  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            acc            <= '0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= S_READ;
`ifdef DUMP_CHECKSUM_EN
                        acc   <= '0;
`endif
                    end
                end
                S_READ: begin
                    data           <= rf_rdata;
                    dump.out_valid <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                    acc            <= acc ^ rf_rdata;
                    dump.out_last  <= 1'b0;
`else
                    dump.out_last  <= (idx == LAST_IDX);
`endif
                    state          <= S_SEND;
                end
                S_SEND: begin
                    if (accept) begin
                        if (idx == LAST_IDX) begin
`ifdef DUMP_CHECKSUM_EN
                            // acc already holds the last register.
                            data          <= acc;
                            dump.out_last <= 1'b1;
                            state         <= S_CSUM;
`else
                            dump.out_valid <= 1'b0;
                            dump.out_last  <= 1'b0;
                            done           <= 1'b1;
                            state          <= S_DONE;
`endif
                        end else begin
                            dump.out_valid <= 1'b0;
                            idx            <= idx + 1'b1;
                            state          <= S_READ;
                        end
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                S_CSUM: begin
                    if (accept) begin
                        dump.out_valid <= 1'b0;
                        dump.out_last  <= 1'b0;
                        done           <= 1'b1;
                        state          <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    dump.out_valid <= 1'b0;
                    dump.out_last  <= 1'b0;
                    done           <= 1'b0;
                    busy           <= 1'b0;
                    state          <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 SHALL have parameter XLEN, default 32, register width in bits.
REQ-002 SHALL have parameter NREGS, default 32, number of registers walked; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 SHALL have port start  input  1  request a full register dump; sampled only in IDLE.
REQ-006 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-007 SHALL have port done  output  1  one-cycle pulse after the final beat is accepted.
REQ-008 SHALL have port rf_raddr  output  $clog2(NREGS)  register file read address.
REQ-009 SHALL have port rf_rdata  input  XLEN  register file read data, combinational from rf_raddr in the same cycle.
REQ-010 SHALL have port out_valid  output  1  output beat valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the beat when out_valid and out_ready are both high at a rising edge.
REQ-012 SHALL have port out_idx  output  $clog2(NREGS)  register index of the current beat.
REQ-013 SHALL have port out_data  output  XLEN  register value of the current beat.
REQ-014 SHALL have port out_last  output  1  marks the final beat of the dump.

Function
REQ-015 SHALL implement the states IDLE, READ, SEND, CSUM and DONE.
REQ-016 IDLE: when start=1, SHALL set idx<=0 and go to READ on the next edge; otherwise SHALL remain in IDLE.
REQ-017 READ: rf_raddr SHALL equal idx; SHALL capture rf_rdata into the data register, fold it into the XOR accumulator, and go to SEND after 1 cycle.
REQ-018 SEND: out_valid=1, out_idx=idx, out_data=captured value; these SHALL remain stable until accepted.
REQ-019 On acceptance in SEND with idx<NREGS-1, SHALL increment idx and go to READ.
REQ-020 On acceptance in SEND with idx=NREGS-1, SHALL go to CSUM when the checksum feature is compiled in, otherwise to DONE.
REQ-021 Latency: with out_ready held at 1, the first beat SHALL be valid 2 cycles after start is sampled, and subsequent beats SHALL follow every 2 cycles.
REQ-022 DONE: done=1 for exactly 1 cycle, then SHALL go to IDLE.
REQ-023 start while busy SHALL be ignored, with no queueing.
REQ-024 rf_raddr SHALL always drive idx, including in IDLE, where idx holds its last value.
REQ-025 out_valid SHALL be 0 in IDLE, READ and DONE.
REQ-026 out_last SHALL be asserted only on the final beat, and only while out_valid=1.

Reset
REQ-027 rst=0 SHALL force IDLE immediately, regardless of clock.
REQ-028 Under reset, idx=0, data=0, accumulator=0, out_valid=0, done=0 and busy=0.
REQ-029 Reset mid-dump SHALL abort the dump without a done pulse; a later start SHALL restart at index 0.

Configuration
REQ-030 Macro DUMP_CHECKSUM_EN: when defined, SHALL append one CSUM beat after register NREGS-1.
  - CSUM beat: out_valid=1, out_idx=0, out_data=XOR of all NREGS values, out_last=1.
  - On acceptance, SHALL go to DONE.
REQ-031 When DUMP_CHECKSUM_EN is not defined, SHALL omit the accumulator and CSUM state, and SHALL set out_last=1 on the register NREGS-1 beat.

Structure
REQ-032 XLEN and NREGS defaults and the dump state enum SHALL live in the shared package cpu_pkg.
REQ-033 SHALL be a single module with no sub-module; the accumulator is a small inline register.

Verification
REQ-034 The bench SHALL cover the following directed scenarios (NREGS=32, XLEN=32, regfile model x[i]=i*0x11111111 except x0=0):
  - Full dump, ready=1: pulse start -> 32 beats, idx 0..31, data per model, first out_valid 2 cycles after start, done 1 cycle after last accept.
  - Backpressure: ready=0 for 5 cycles on beat 7 -> out_valid, out_idx=7 and out_data=0x77777777 held stable; no skipped or duplicated beats.
  - DUMP_CHECKSUM_EN build -> 33rd beat with out_data = XOR of x0..x31 and out_last=1; beat 31 has out_last=0. Without the macro -> beat 31 has out_last=1.
  - start pulsed at beat 10 -> ignored; exactly one dump; busy continuous.
  - rst=0 asynchronously at beat 12 -> out_valid and busy drop before the next edge; no done; a new start yields idx 0 first.
  - Back-to-back: start re-asserted the cycle after done -> a second identical dump begins; rf_raddr=0 in its first READ.
